sr_ff_driver: RTL
=================

Name: sr_ff_driver

Overview:
Command-side counterpart to the SR flip-flop. It accepts a stream of desired flip-flop states over a valid/ready handshake and converts each one into an SR excitation code using the SR excitation table. It drives the code onto an external SR flip-flop, then checks the flip-flop's q feedback against the expected value. It never issues the illegal 11 code and keeps saturating statistics for the test benches.

Parameters:
CNT_W, 8, width of the command and mismatch counters
FORCE_DRIVE, 0, when 1 every accepted target issues set/reset and 00 (hold) is never generated

Ports:
clk  input  1  rising-edge clock shared with the driven flip-flop
rst  input  1  asynchronous active-high reset
tgt_valid  input  1  target bit offered
tgt_bit  input  1  desired next q of the flip-flop
tgt_ready  output  1  driver can accept a target
sr  output  2  excitation to flip-flop, {S,R}: 00 hold, 01 reset, 10 set
q_fb  input  1  q output of the driven flip-flop
busy  output  1  command in flight (state not IDLE)
err  output  1  sticky mismatch flag
err_clr  input  1  clears err (synchronous)
cmd_count  output  CNT_W  count of non-hold commands issued, saturating
mis_count  output  CNT_W  count of feedback mismatches, saturating

Behaviour:
- Reset is asynchronous and active-high.
  - On assertion: state=IDLE, sr=00, exp_q=0 (matches flip-flop power-up 0), resync=0, err=0, both counters 0, busy=0, tgt_ready=1.
  - Reset mid-command abandons the command; nothing is counted.
- All outputs are registered except tgt_ready and busy, which decode directly from state.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1, sr=00.
  - Acceptance occurs at edge E when tgt_valid=1.
  - Excitation: if tgt_bit==exp_q and FORCE_DRIVE=0 and resync=0, then sr<=00. Otherwise sr<={tgt_bit,~tgt_bit}.
  - exp_q<=tgt_bit; resync<=0.
  - cmd_count increments when the issued sr is not 00.
  - Go to DRIVE.
- DRIVE: sr is held for exactly one cycle, and the flip-flop samples it at edge E+1. At E+1, sr<=00 and the block goes to CHECK.
- CHECK: at edge E+2, compare q_fb with exp_q.
  - A value of 0 or 1 that differs is a mismatch. In simulation, X or Z on q_fb is also a mismatch (case-inequality compare).
  - On mismatch: err<=1, mis_count increments, resync<=1. exp_q keeps the target value.
  - Either way, go to IDLE.
- Handshake and throughput:
  - Tgt_ready is low in DRIVE and CHECK; tgt_valid is ignored there.
  - Maximum throughput is one target per 3 cycles.
  - Back-to-back targets: if accepted at E, the next can be accepted at E+3.
- Resync: after a mismatch, the next accepted target always drives set or reset, even when equal to exp_q, so the flip-flop is forced to a known value.
- sr is never 11 under any input, including a stuck-X q_fb.
- err:
  - Cleared by err_clr in any state.
  - If err_clr and a mismatch coincide at the same edge, the mismatch wins and err=1.
  - err_clr does not affect the counters.
- Counters saturate at 2^CNT_W-1 with no wrap.
- tgt_bit is sampled only at acceptance; later changes have no effect on the command in flight.

Test Plan:
- Reset then tgt sequence 1,1,0,0,1 with the real SR_FF attached, FORCE_DRIVE=0 -> sr sequence 10,00,01,00,10, each for one cycle at E+1. q follows targets, err=0, cmd_count=3, mis_count=0.
- Same sequence with FORCE_DRIVE=1 -> sr 10,10,01,01,10; cmd_count=5; sr never 00 during DRIVE.
- q_fb forced stuck at 0, target 1 -> at E+2 err=1 and mis_count=1. Next target 1 issues sr=10 (resync), not 00.
- tgt_valid held high continuously -> acceptances exactly every 3 cycles; tgt_ready low in DRIVE/CHECK; sr returns to 00 between commands.
- Assert rst while in DRIVE with sr=10 -> sr=00, busy=0 and tgt_ready=1 immediately (asynchronous); counters 0.
- CNT_W=2, issue 5 alternating targets -> cmd_count saturates at 3. err_clr asserted in the same cycle as a mismatch -> err stays 1.

Source files
------------

// File: rtl/sr_ff_driver.sv
// rtl/sr_ff_driver.sv - converts a stream of target states into SR excitations and checks q feedback
module sr_ff_driver #(
    parameter int CNT_W       = 8,
    parameter bit FORCE_DRIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic [1:0]       sr,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] mis_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [1:0]       sr_q, sr_d;
    logic             exp_q, exp_d;
    logic             resync_q, resync_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cmd_q, cmd_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic             mismatch;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        exp_d    = exp_q;
        resync_d = resync_q;
        cmd_d    = cmd_q;
        mis_d    = mis_q;
        mismatch = 1'b0;

        case (state_q)
            IDLE: begin
                sr_d = 2'b00;
                if (tgt_valid) begin
                    // A hold is only trusted while the flip-flop is known to match exp_q
                    if ((tgt_bit == exp_q) && !FORCE_DRIVE && !resync_q)
                        sr_d = 2'b00;
                    else
                        sr_d = {tgt_bit, ~tgt_bit};
                    exp_d    = tgt_bit;
                    resync_d = 1'b0;
                    if ((sr_d != 2'b00) && (cmd_q != CNT_MAX))
                        cmd_d = cmd_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                sr_d    = 2'b00;
                state_d = CHECK;
            end
            CHECK: begin
                // Case inequality so an X/Z feedback in simulation is flagged too
                mismatch = (q_fb !== exp_q);
                state_d  = IDLE;
            end
            default: begin
                sr_d    = 2'b00;
                state_d = IDLE;
            end
        endcase

        err_d = err_clr ? 1'b0 : err_q;
        if (mismatch) begin
            err_d    = 1'b1;
            resync_d = 1'b1;
            if (mis_q != CNT_MAX)
                mis_d = mis_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= 2'b00;
            exp_q    <= 1'b0;
            resync_q <= 1'b0;
            err_q    <= 1'b0;
            cmd_q    <= '0;
            mis_q    <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            exp_q    <= exp_d;
            resync_q <= resync_d;
            err_q    <= err_d;
            cmd_q    <= cmd_d;
            mis_q    <= mis_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sr        = sr_q;
    assign err       = err_q;
    assign cmd_count = cmd_q;
    assign mis_count = mis_q;

endmodule
